// File: rtl/video_timing_gen_pkg.sv
// Shared types for the video timing generator: counter width, FSM states,
// the registered output bundle and a half-open range helper.
package video_timing_gen_pkg;

  localparam int COUNT_W = 10;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  typedef struct packed {
    logic   running;
    logic   hsync;
    logic   vsync;
    logic   de;
    count_t x;
    count_t y;
    logic   line_start;
    logic   frame_start;
  } vid_out_t;

  // True when lo <= val < hi.
  function automatic logic in_window(count_t val, count_t lo, count_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing output bundle; the generator drives it, sinks observe it.
interface video_timing_gen_if;
  import video_timing_gen_pkg::*;

  logic   running;
  logic   hsync;
  logic   vsync;
  logic   de;
  count_t x;
  count_t y;
  logic   line_start;
  logic   frame_start;

  modport master (
    output running, hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    input running, hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow-changing status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous bit through two flops; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_timing_defs.vh
// Default 640x480@60 timing constants, shared with downstream HDMI/TMDS stages.
`ifndef VIDEO_TIMING_DEFS_VH
`define VIDEO_TIMING_DEFS_VH

`define VT_H_ACTIVE 640
`define VT_H_FP     16
`define VT_H_SYNC   96
`define VT_H_BP     48
`define VT_V_ACTIVE 480
`define VT_V_FP     10
`define VT_V_SYNC   2
`define VT_V_BP     33

`define VT_H_TOTAL (`VT_H_ACTIVE + `VT_H_FP + `VT_H_SYNC + `VT_H_BP)
`define VT_V_TOTAL (`VT_V_ACTIVE + `VT_V_FP + `VT_V_SYNC + `VT_V_BP)

`endif

// File: rtl/video_timing_gen.sv
// Lock-qualified raster timing generator: waits for a stable PLL lock, then
// scans h/v counters and emits registered, mutually aligned sync/DE/position.
`include "video_timing_defs.vh"

module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE    = `VT_H_ACTIVE,
  parameter int H_FP        = `VT_H_FP,
  parameter int H_SYNC      = `VT_H_SYNC,
  parameter int H_BP        = `VT_H_BP,
  parameter int V_ACTIVE    = `VT_V_ACTIVE,
  parameter int V_FP        = `VT_V_FP,
  parameter int V_SYNC      = `VT_V_SYNC,
  parameter int V_BP        = `VT_V_BP,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_CYCLES = 16
) (
  input  logic               clk_pixel,
  input  logic               rst,
  input  logic               pll_locked,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_ACT     = count_t'(H_ACTIVE);
  localparam count_t H_SYNC_LO = count_t'(H_ACTIVE + H_FP);
  localparam count_t H_SYNC_HI = count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t H_LAST    = count_t'(H_TOTAL - 1);
  localparam count_t V_ACT     = count_t'(V_ACTIVE);
  localparam count_t V_SYNC_LO = count_t'(V_ACTIVE + V_FP);
  localparam count_t V_SYNC_HI = count_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam count_t V_LAST    = count_t'(V_TOTAL - 1);

  localparam int                QUAL_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(LOCK_CYCLES - 1);

  localparam vid_out_t IDLE_OUT = '{
    running:     1'b0,
    hsync:       ~HSYNC_POL,
    vsync:       ~VSYNC_POL,
    de:          1'b0,
    x:           '0,
    y:           '0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic              lock_s;
  state_t            state_reg, state_next;
  logic [QUAL_W-1:0] qual_reg, qual_next;
  count_t            h_reg, h_next;
  count_t            v_reg, v_next;
  vid_out_t          out_reg, out_next;

  sync_2ff u_lock_sync (
    .clk (clk_pixel),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Register FSM state, qualification counter, raster counters and outputs.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_reg <= WAIT_LOCK;
      qual_reg  <= '0;
      h_reg     <= '0;
      v_reg     <= '0;
      out_reg   <= IDLE_OUT;
    end else begin
      state_reg <= state_next;
      qual_reg  <= qual_next;
      h_reg     <= h_next;
      v_reg     <= v_next;
      out_reg   <= out_next;
    end
  end

  // Next-state logic: qualify lock, then scan the raster until lock drops.
  always_comb begin
    state_next = state_reg;
    qual_next  = qual_reg;
    h_next     = h_reg;
    v_next     = v_reg;
    case (state_reg)
      WAIT_LOCK: begin
        h_next = '0;
        v_next = '0;
        if (!lock_s) begin
          qual_next = '0;
        end else if (qual_reg == QUAL_LAST) begin
          // This cycle is the LOCK_CYCLES-th consecutive high sample.
          state_next = RUN;
          qual_next  = '0;
        end else begin
          qual_next = qual_reg + QUAL_W'(1);
        end
      end
      RUN: begin
        qual_next = '0;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          h_next     = '0;
          v_next     = '0;
        end else if (h_reg == H_LAST) begin
          h_next = '0;
          v_next = (v_reg == V_LAST) ? '0 : v_reg + count_t'(1);
        end else begin
          h_next = h_reg + count_t'(1);
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        qual_next  = '0;
        h_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  // Decode the current (h,v) into the next output word; a falling lock
  // blanks the outputs immediately rather than one cycle later.
  always_comb begin
    out_next = IDLE_OUT;
    if (state_reg == RUN && lock_s) begin
      out_next.running     = 1'b1;
      out_next.de          = (h_reg < H_ACT) && (v_reg < V_ACT);
      out_next.hsync       = in_window(h_reg, H_SYNC_LO, H_SYNC_HI) ? HSYNC_POL : ~HSYNC_POL;
      out_next.vsync       = in_window(v_reg, V_SYNC_LO, V_SYNC_HI) ? VSYNC_POL : ~VSYNC_POL;
      out_next.x           = out_next.de ? h_reg : '0;
      out_next.y           = out_next.de ? v_reg : '0;
      out_next.line_start  = (h_reg == '0) && (v_reg < V_ACT);
      out_next.frame_start = (h_reg == '0) && (v_reg == '0);
    end
  end

  assign vid.running     = out_reg.running;
  assign vid.hsync       = out_reg.hsync;
  assign vid.vsync       = out_reg.vsync;
  assign vid.de          = out_reg.de;
  assign vid.x           = out_reg.x;
  assign vid.y           = out_reg.y;
  assign vid.line_start  = out_reg.line_start;
  assign vid.frame_start = out_reg.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a reduced raster so whole
// frames fit in a short run; two instances cover both sync polarities.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LK = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen_if vid0();
  video_timing_gen_if vid1();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_CYCLES(LK)
  ) dut0 (
    .clk_pixel  (clk),
    .rst        (rst),
    .pll_locked (pll),
    .vid        (vid0)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_CYCLES(LK)
  ) dut1 (
    .clk_pixel  (clk),
    .rst        (rst),
    .pll_locked (pll),
    .vid        (vid1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected output word {running,hsync,vsync,de,x,y,line_start,frame_start}
  // for linear pixel index t, derived directly from the raster definition.
  function automatic logic [25:0] expect_out(bit act, int t, bit ph, bit pv);
    int h, v;
    bit de_e, hs_act, vs_act;
    if (!act) return {1'b0, ~ph, ~pv, 1'b0, 10'd0, 10'd0, 2'b00};
    h = t % HT;
    v = t / HT;
    de_e   = (h < HA) && (v < VA);
    hs_act = (h >= HA + HF) && (h < HA + HF + HS);
    vs_act = (v >= VA + VF) && (v < VA + VF + VS);
    return {1'b1, hs_act ? ph : ~ph, vs_act ? pv : ~pv, de_e,
            de_e ? 10'(h) : 10'd0, de_e ? 10'(v) : 10'd0,
            (h == 0) && (v < VA), (h == 0) && (v == 0)};
  endfunction

  typedef struct {
    logic [25:0] e0;
    logic [25:0] e1;
  } exp_t;

  exp_t sb[$];

  // Reference model state: sync pipe, running flag, lock streak, pixel index.
  bit m_p1 = 1'b0, m_p2 = 1'b0, m_run = 1'b0;
  int m_q = 0, m_t = 0;

  // Drive one cycle of stimulus, predict the outputs of the coming edge,
  // and return just after that edge.
  task automatic step(input bit r, input bit p);
    exp_t e;
    bit act;
    @(negedge clk);
    #1;
    if (r) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_run = 1'b0; m_q = 0; m_t = 0;
      e.e0 = expect_out(1'b0, 0, 1'b0, 1'b0);
      e.e1 = expect_out(1'b0, 0, 1'b1, 1'b1);
    end else begin
      act  = m_run && m_p2;
      e.e0 = expect_out(act, m_t, 1'b0, 1'b0);
      e.e1 = expect_out(act, m_t, 1'b1, 1'b1);
      if (m_run) begin
        if (!m_p2) begin
          m_run = 1'b0;
          m_t   = 0;
        end else begin
          m_t = (m_t + 1) % FRAME;
        end
      end else if (!m_p2) begin
        m_q = 0;
      end else if (m_q + 1 == LK) begin
        m_run = 1'b1;
        m_q   = 0;
        m_t   = 0;
      end else begin
        m_q++;
      end
      m_p2 = m_p1;
      m_p1 = p;
    end
    sb.push_back(e);
    rst = r;
    pll = p;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each edge's outputs against the predicted word.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("out_pol0", {vid0.running, vid0.hsync, vid0.vsync, vid0.de, vid0.x, vid0.y,
                            vid0.line_start, vid0.frame_start}, 32'(e.e0));
      check_eq("out_pol1", {vid1.running, vid1.hsync, vid1.vsync, vid1.de, vid1.x, vid1.y,
                            vid1.line_start, vid1.frame_start}, 32'(e.e1));
    end
  end

  // Hold lock high and count edges until frame_start; 0 means timed out.
  task automatic wait_frame_start(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b1);
      if (vid0.frame_start) begin
        n = i;
        break;
      end
    end
  endtask

  // Hold lock high until the visible pixel (wx,wy) is on the outputs.
  task automatic wait_pixel(input int wx, input int wy, output int n);
    n = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      step(1'b0, 1'b1);
      if (vid0.de && vid0.x == 10'(wx) && vid0.y == 10'(wy)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int de_cnt, hs_cyc, hs_pulses, hs_first, vs_cyc, vs_first, hs1_cyc;
    bit hs_prev;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_eq("rst_running", vid0.running, 0);
    check_eq("rst_hsync_pol0", vid0.hsync, 1);
    check_eq("rst_vsync_pol1", vid1.vsync, 0);

    // Lock from the first unreset edge: first pixel after 2+16+1 edges.
    wait_frame_start(n);
    check_eq("lock_latency", n, 19);
    check_eq("first_de", vid0.de, 1);

    // One full frame of statistics starting at pixel (0,0).
    de_cnt = 0; hs_cyc = 0; hs_pulses = 0; hs_first = -1;
    vs_cyc = 0; vs_first = -1; hs1_cyc = 0; hs_prev = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      de_cnt += int'(vid0.de);
      if (!vid0.hsync) begin
        hs_cyc++;
        if (!hs_prev) begin
          hs_pulses++;
          if (hs_first < 0) hs_first = i;
        end
      end
      hs_prev = !vid0.hsync;
      if (!vid0.vsync) begin
        vs_cyc++;
        if (vs_first < 0) vs_first = i;
      end
      if (vid1.hsync) hs1_cyc++;
      step(1'b0, 1'b1);
    end
    check_eq("frame_de_cycles", de_cnt, HA * VA);
    check_eq("frame_hs_pulses", hs_pulses, VT);
    check_eq("frame_hs_cycles", hs_cyc, VT * HS);
    check_eq("frame_hs_start", hs_first, HA + HF);
    check_eq("frame_vs_cycles", vs_cyc, VS * HT);
    check_eq("frame_vs_start", vs_first, (VA + VF) * HT);
    check_eq("frame_hs_cycles_pol1", hs1_cyc, VT * HS);
    check_eq("frame_wrap", vid0.frame_start, 1);

    // Lock drop mid-line: outputs must go idle within 3 edges.
    wait_pixel(10, 3, n);
    check_eq("find_10_3", n > 0, 1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      if (!vid0.running) begin
        n = i;
        break;
      end
    end
    check_eq("drop_idle_within_3", (n >= 1) && (n <= 3), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Short glitch during qualification restarts the count.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("glitch_not_running", vid0.running, 0);
    wait_frame_start(n);
    check_eq("relock_latency", n, 19);

    // Reset mid-frame inside the hsync pulse.
    wait_pixel(0, 5, n);
    check_eq("find_0_5", n > 0, 1);
    for (int i = 0; i < HA + HF + 2; i++) step(1'b0, 1'b1);
    check_eq("pre_rst_hsync", vid0.hsync, 0);
    step(1'b1, 1'b1);
    check_eq("midrst_running", vid0.running, 0);
    check_eq("midrst_hsync_pol0", vid0.hsync, 1);
    check_eq("midrst_hsync_pol1", vid1.hsync, 0);
    wait_frame_start(n);
    check_eq("post_rst_latency", n, 19);

    for (int i = 0; i < 60; i++) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_eq("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active sync level (0 = active-low)
- LOCK_CYCLES, 16, consecutive synchronised-lock cycles required before timing starts
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_pixel, in, 1, 25 MHz pixel clock and the block's only clock
- rst, in, 1, reset, synchronous and active-high
- pll_locked, in, 1, PLL lock indicator, asynchronous to clk_pixel
- running, out, 1, timing generator active
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, display enable (pixel visible)
- x, out, 10, current pixel column
- y, out, 10, current pixel line
- line_start, out, 1, one-cycle pulse on the first pixel of each visible line
- frame_start, out, 1, one-cycle pulse on pixel (0,0)

Function
REQ-003 pll_locked SHALL pass through a 2-flop synchroniser before any use.
REQ-004 The block SHALL be a two-state FSM, WAIT_LOCK and RUN.
REQ-005 In WAIT_LOCK, a qualification counter SHALL increment each cycle the synchronised lock is 1 and clear to 0 each cycle it is 0.
REQ-006 When the qualification counter reaches LOCK_CYCLES, the FSM SHALL move to RUN, with h_count=0 and v_count=0.
REQ-007 In RUN, h_count SHALL count 0..H_TOTAL-1 (800) and then wrap to 0; v_count SHALL increment on each h wrap, over 0..V_TOTAL-1 (525), and then wrap to 0.
REQ-008 H_TOTAL and V_TOTAL SHALL be the sums of their four component parameters; counters SHALL be 10 bits wide.
REQ-009 All outputs SHALL be registered and mutually aligned, so that the outputs for count (h,v) appear together in the same cycle.
REQ-010 The first RUN output cycle SHALL present pixel (0,0).
REQ-011 de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-012 hsync SHALL be at its active level iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise it SHALL be inactive.
REQ-013 vsync SHALL be at its active level iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491); it SHALL change only at h=0 cycles.
REQ-014 x and y SHALL equal h and v when de=1, and SHALL be 0 otherwise.
REQ-015 line_start SHALL be 1 iff h=0 and v<V_ACTIVE.
REQ-016 frame_start SHALL be 1 iff h=0 and v=0.
REQ-017 running SHALL be 1 in every RUN output cycle.
REQ-018 If the synchronised lock falls in RUN, the FSM SHALL return to WAIT_LOCK on the next edge, abandoning the frame mid-line.
REQ-019 On re-entry to WAIT_LOCK the block SHALL drive idle outputs and require full requalification before restarting at (0,0).
REQ-020 A lock glitch shorter than LOCK_CYCLES during WAIT_LOCK SHALL restart qualification from 0.
REQ-021 Idle outputs (WAIT_LOCK) SHALL be: de=0, running=0, line_start=0, frame_start=0, x=0, y=0, and hsync/vsync at their inactive levels (~HSYNC_POL, ~VSYNC_POL).

Reset
REQ-022 When rst=1 is sampled, the FSM SHALL enter WAIT_LOCK, the synchroniser flops and all counters SHALL clear, and all outputs SHALL take their idle values on the same edge.
REQ-023 rst asserted mid-frame SHALL take priority over all other events.

Structure
REQ-024 The default 640x480 timing constants and the derived H_TOTAL/V_TOTAL SHALL live in a shared include, video_timing_defs.vh, for reuse by downstream HDMI/TMDS stages.
REQ-025 The lock synchroniser SHALL be a separate sub-module, sync_2ff (1-bit, parameterless), reusable for other cross-domain status bits.

Verification
REQ-026 With rst released and pll_locked held 1 from cycle 0: de=1, frame_start=1 and x=y=0 SHALL first appear exactly 19 rising edges after pll_locked is first sampled (2 sync + 16 qualify + 1 output).
REQ-027 Over one full frame: exactly 307200 de cycles, 525 hsync pulses each 96 cycles wide starting at h=656, and one 1600-cycle vsync pulse starting at v=490, h=0.
REQ-028 pll_locked toggled 1 for 10 cycles then 0 for 1 cycle then 1: running SHALL stay 0 until 16 consecutive synchronised-high cycles are seen after the glitch.
REQ-029 pll_locked dropped at (h=300,v=200): within 3 cycles all outputs SHALL be idle; after relock, the restart SHALL be at (0,0) with frame_start=1.
REQ-030 rst pulsed at (h=700,v=100): next cycle outputs SHALL be idle, then restart SHALL occur after the qualify delay.
REQ-031 With HSYNC_POL=1 and VSYNC_POL=1: sync outputs SHALL be inverted, idle at 0, with pulse positions unchanged.
